// File: rtl/frame_fill_blitter.sv
// Rectangle-fill writer for the 160x120x6 VGA frame buffer, one pixel per clk, clipped to screen.
// Optional build macro FILL_VBLANK_ONLY_EN: only write pixels while blank=1, stalling otherwise.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready=1
// SETUP | clip rectangle, compute start row base
// FILL  | write one pixel per enabled cycle; flags done once row reaches y1
// DONE  | done pulse visible, returns to IDLE
module frame_fill_blitter #(
    parameter int H_RES   = 160,
    parameter int V_RES   = 120,
    parameter int ADDR_W  = 15,
    parameter int COLOR_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [7:0]         cmd_x,
    input  logic [6:0]         cmd_y,
    input  logic [7:0]         cmd_w,
    input  logic [6:0]         cmd_h,
    input  logic [COLOR_W-1:0] cmd_color,
    input  logic               blank,
    output logic               busy,
    output logic               done,
    output logic               write_enable,
    output logic [COLOR_W-1:0] din,
    output logic [ADDR_W-1:0]  din_address
);

    typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

    localparam logic [8:0]        X_LIM    = 9'(H_RES);
    localparam logic [7:0]        Y_LIM    = 8'(V_RES);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_RES);

    state_t               state;
    logic [7:0]           lx, lw, col, x_last;
    logic [6:0]           ly, lh, row, y1;
    logic [COLOR_W-1:0]   lcolor;
    logic [ADDR_W-1:0]    row_base;

    logic [8:0] x_end, x1c;
    logic [7:0] y_end, y1c;
    logic       empty;
    logic       pix_en;

    always_comb begin
        x_end = {1'b0, lx} + {1'b0, lw};
        x1c   = (x_end > X_LIM) ? X_LIM : x_end;
        y_end = {1'b0, ly} + {1'b0, lh};
        y1c   = (y_end > Y_LIM) ? Y_LIM : y_end;
        empty = ({1'b0, lx} >= x1c) || ({1'b0, ly} >= y1c);
    end

`ifdef FILL_VBLANK_ONLY_EN
    assign pix_en = blank;
`else
    logic unused_blank;
    assign unused_blank = blank;
    assign pix_en       = 1'b1;
`endif

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            done         <= 1'b0;
            write_enable <= 1'b0;
            din          <= '0;
            din_address  <= '0;
            lx           <= '0;
            ly           <= '0;
            lw           <= '0;
            lh           <= '0;
            lcolor       <= '0;
            col          <= '0;
            row          <= '0;
            x_last       <= '0;
            y1           <= '0;
            row_base     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    write_enable <= 1'b0;
                    done         <= 1'b0;
                    if (cmd_valid) begin
                        lx     <= cmd_x;
                        ly     <= cmd_y;
                        lw     <= cmd_w;
                        lh     <= cmd_h;
                        lcolor <= cmd_color;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    write_enable <= 1'b0;
                    col          <= lx;
                    x_last       <= 8'(x1c - 9'd1);
                    y1           <= 7'(y1c);
                    // an empty rectangle starts already finished, so FILL ends without writing
                    row          <= empty ? 7'(y1c) : ly;
                    row_base     <= ADDR_W'(ly) * ROW_STEP;
                    state        <= FILL;
                end
                FILL: begin
                    if (row == y1) begin
                        write_enable <= 1'b0;
                        done         <= 1'b1;
                        state        <= DONE;
                    end else if (pix_en) begin
                        write_enable <= 1'b1;
                        din          <= lcolor;
                        din_address  <= row_base + ADDR_W'(col);
                        if (col == x_last) begin
                            col      <= lx;
                            row      <= row + 7'd1;
                            row_base <= row_base + ROW_STEP;
                        end else begin
                            col <= col + 8'd1;
                        end
                    end else begin
                        write_enable <= 1'b0;
                    end
                end
                DONE: begin
                    write_enable <= 1'b0;
                    done         <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
